// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU between register-read and writeback.
// Single-cycle ops load the result register directly; op 1111 is either a
// WIDTH-cycle shift-add multiply (ALU_MUL_EN defined) or an alias of op 1110.
// Optional feature macro: ALU_MUL_EN
//
// state | meaning
// IDLE  | ready for a new op when the output slot is free or draining
// MUL   | shift-add multiply in progress, one partial-product step per cycle
module alu_seq #(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [3:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_res,
  output logic             out_neg,
  output logic             out_zero,
  output logic             out_cout
);

  logic             in_fire;
  logic             out_fire;
  logic             load_res;
  logic             mul_done;
  logic [WIDTH-1:0] mul_prod;
  logic [WIDTH-1:0] res_c;
  logic             cout_c;
  logic [WIDTH:0]   sum;
  logic [SHW-1:0]   sh;
  logic [2*WIDTH-1:0] rotl_d;
  logic [2*WIDTH-1:0] rotr_d;
  logic [WIDTH-1:0] rev;
  logic [WIDTH-1:0] pack_ab;

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  // Bit reversal of operand A.
  always_comb begin
    rev = '0;
    for (int i = 0; i < WIDTH; i++) begin
      rev[i] = in_a[WIDTH-1-i];
    end
  end

  // Single-cycle result and carry for the op presented at the input.
  always_comb begin
    sum     = {1'b0, in_a} + {1'b0, in_b};
    sh      = in_b[SHW-1:0];
    rotl_d  = {in_a, in_a} << sh;
    rotr_d  = {in_a, in_a} >> sh;
    pack_ab = (in_a << (WIDTH/2)) | in_b;
    res_c   = '0;
    cout_c  = 1'b0;
    case (in_op)
      4'b0000: res_c = in_b - in_a;
      4'b0001: begin
        res_c  = sum[WIDTH-1:0];
        cout_c = sum[WIDTH];
      end
      4'b0010: res_c = in_a & ~in_b;
      4'b0011: res_c = in_a ^ in_b;
      4'b0100: res_c = rotl_d[2*WIDTH-1:WIDTH];
      4'b0101: res_c = in_a << sh;
      4'b0110: res_c = rotr_d[WIDTH-1:0];
      4'b0111: res_c = in_a >> sh;
      4'b1000: res_c = rev;
      4'b1001: res_c = {{(WIDTH-1){1'b0}}, in_a == in_b};
      4'b1010: res_c = {{(WIDTH-1){1'b0}}, $signed(in_a) < $signed(in_b)};
      4'b1011: res_c = {{(WIDTH-1){1'b0}}, $signed(in_a) <= $signed(in_b)};
      4'b1100: begin
        res_c  = {{(WIDTH-1){1'b0}}, sum[WIDTH]};
        cout_c = sum[WIDTH];
      end
      4'b1101: res_c = in_b;
      default: res_c = pack_ab;  // 1110, and 1111 when no multiplier is built
    endcase
  end

`ifdef ALU_MUL_EN
  typedef enum logic {IDLE, MUL} state_t;

  state_t           state;
  state_t           state_nxt;
  logic             start_mul;
  logic [SHW-1:0]   cnt;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc_step;

  assign in_ready = (state == IDLE) && (!out_valid || out_ready);
  assign acc_step = acc + (mplier[0] ? mcand : '0);
  assign mul_prod = acc_step;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state and per-cycle control strobes.
  always_comb begin
    state_nxt = state;
    load_res  = 1'b0;
    start_mul = 1'b0;
    mul_done  = 1'b0;
    case (state)
      IDLE: begin
        if (in_fire) begin
          if (in_op == 4'b1111) begin
            start_mul = 1'b1;
            state_nxt = MUL;
          end else begin
            load_res = 1'b1;
          end
        end
      end
      MUL: begin
        if (cnt == SHW'(WIDTH-1)) begin
          mul_done  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Shift-add datapath: multiplicand walks left, multiplier walks right.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else if (start_mul) begin
      cnt    <= '0;
      acc    <= '0;
      mcand  <= in_a;
      mplier <= in_b;
    end else if (state == MUL) begin
      cnt    <= cnt + 1'b1;
      acc    <= acc_step;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
    end
  end
`else
  assign in_ready = !out_valid || out_ready;
  assign load_res = in_fire;
  assign mul_done = 1'b0;
  assign mul_prod = '0;
`endif

  // Output register: holds result and flags until the consumer takes them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_res   <= '0;
      out_neg   <= 1'b0;
      out_zero  <= 1'b0;
      out_cout  <= 1'b0;
    end else if (load_res) begin
      out_valid <= 1'b1;
      out_res   <= res_c;
      out_neg   <= res_c[WIDTH-1];
      out_zero  <= (res_c == '0);
      out_cout  <= cout_c;
    end else if (mul_done) begin
      out_valid <= 1'b1;
      out_res   <= mul_prod;
      out_neg   <= mul_prod[WIDTH-1];
      out_zero  <= (mul_prod == '0);
      out_cout  <= 1'b0;
    end else if (out_fire) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq (WIDTH=16). Expected multiply behaviour follows
// ALU_MUL_EN so the same bench serves both builds.
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_a = '0;
  logic [15:0] in_b = '0;
  logic [3:0]  in_op = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_res;
  logic        out_neg;
  logic        out_zero;
  logic        out_cout;

  int checks = 0;
  int failures = 0;

  alu_seq #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_res(out_res), .out_neg(out_neg), .out_zero(out_zero), .out_cout(out_cout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    logic        neg;
    logic        zero;
    logic        cout;
  } vec_t;

  localparam int NV = 20;
  vec_t vecs[NV];

`ifdef ALU_MUL_EN
  localparam int          MUL_LAT = 16;
  localparam logic [15:0] MUL_RES = 16'h5F90;
`else
  localparam int          MUL_LAT = 0;
  localparam logic [15:0] MUL_RES = 16'h2D2C;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] obs();
    return 32'({out_valid, out_neg, out_zero, out_cout, out_res});
  endfunction

  function automatic logic [31:0] expv(input logic v, input logic n, input logic z,
                                       input logic c, input logic [15:0] r);
    return 32'({v, n, z, c, r});
  endfunction

  task automatic apply(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
  endtask

  initial begin
    int  n;
    bit  rdy_bad;
    bit  stale;

    vecs[0]  = '{4'b0001, 16'hFFFF, 16'h0001, 16'h0000, 1'b0, 1'b1, 1'b1};
    vecs[1]  = '{4'b0000, 16'h0003, 16'h0001, 16'hFFFE, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{4'b0010, 16'hF0F0, 16'hFF00, 16'h00F0, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{4'b0011, 16'hAAAA, 16'h5555, 16'hFFFF, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{4'b0100, 16'h8001, 16'h0004, 16'h0018, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{4'b0101, 16'h8001, 16'h0014, 16'h0010, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{4'b0110, 16'h8001, 16'h0004, 16'h1800, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{4'b0111, 16'h8001, 16'h0000, 16'h8001, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{4'b0111, 16'h8001, 16'h000F, 16'h0001, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{4'b1000, 16'h1234, 16'h0000, 16'h2C48, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{4'b1000, 16'h0001, 16'h0000, 16'h8000, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{4'b1010, 16'h8000, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{4'b1010, 16'h7FFF, 16'h8000, 16'h0000, 1'b0, 1'b1, 1'b0};
    vecs[13] = '{4'b1011, 16'h1234, 16'h1234, 16'h0001, 1'b0, 1'b0, 1'b0};
    vecs[14] = '{4'b1001, 16'h0005, 16'h0006, 16'h0000, 1'b0, 1'b1, 1'b0};
    vecs[15] = '{4'b1001, 16'h0005, 16'h0005, 16'h0001, 1'b0, 1'b0, 1'b0};
    vecs[16] = '{4'b1100, 16'hFFFF, 16'h0002, 16'h0001, 1'b0, 1'b0, 1'b1};
    vecs[17] = '{4'b1100, 16'h0001, 16'h0002, 16'h0000, 1'b0, 1'b1, 1'b0};
    vecs[18] = '{4'b1101, 16'h0001, 16'hBEEF, 16'hBEEF, 1'b1, 1'b0, 1'b0};
    vecs[19] = '{4'b1110, 16'h00AB, 16'h00CD, 16'hABCD, 1'b1, 1'b0, 1'b0};

    // Reset state
    #12;
    chk("reset_outputs", obs(), 32'h0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("reset_in_ready", 32'(in_ready), 32'h1);

    // Back-to-back table with out_ready held high
    out_ready = 1'b1;
    for (int i = 0; i < NV; i++) begin
      apply(vecs[i].op, vecs[i].a, vecs[i].b);
      @(posedge clk); #1;
      chk($sformatf("vec%0d_op%b", i, vecs[i].op), obs(),
          expv(1'b1, vecs[i].neg, vecs[i].zero, vecs[i].cout, vecs[i].res));
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("drain_no_accept", 32'(out_valid), 32'h0);

    // Backpressure: result held, later inputs ignored
    out_ready = 1'b0;
    apply(4'b0100, 16'h8001, 16'h0004);
    @(posedge clk); #1;
    chk("bp_load", obs(), expv(1'b1, 1'b0, 1'b0, 1'b0, 16'h0018));
    apply(4'b1101, 16'h0000, 16'hDEAD);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("bp_in_ready_c%0d", k), 32'(in_ready), 32'h0);
      @(posedge clk); #1;
      chk($sformatf("bp_hold_c%0d", k), obs(), expv(1'b1, 1'b0, 1'b0, 1'b0, 16'h0018));
    end
    out_ready = 1'b1;
    apply(4'b0011, 16'h00FF, 16'h0F0F);
    #1;
    chk("bp_release_in_ready", 32'(in_ready), 32'h1);
    @(posedge clk); #1;
    chk("bp_swap_result", obs(), expv(1'b1, 1'b0, 1'b0, 1'b0, 16'h0FF0));
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("bp_final_drain", 32'(out_valid), 32'h0);

    // Asynchronous reset discards a held result
    out_ready = 1'b0;
    apply(4'b1101, 16'h0000, 16'hBEEF);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("held_before_reset", obs(), expv(1'b1, 1'b1, 1'b0, 1'b0, 16'hBEEF));
    #2 rst_n = 1'b0;
    #1;
    chk("reset_discards_held", obs(), 32'h0);
    @(negedge clk) rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("after_reset_ready", 32'({in_ready, out_valid}), 32'h2);

    // Multiply latency and result; a competing op is held on the input meanwhile
    apply(4'b1111, 16'd300, 16'd300);
    @(posedge clk); #1;
    apply(4'b1101, 16'h0000, 16'h1111);
    n = -1;
    rdy_bad = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (out_valid) begin
        in_valid = 1'b0;
        n = k;
        break;
      end
      if (in_ready) rdy_bad = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("mul_latency", 32'(n), 32'(MUL_LAT));
    chk("mul_result", obs(), expv(1'b1, 1'b0, 1'b0, 1'b0, MUL_RES));
    chk("mul_in_ready_low", 32'(rdy_bad), 32'h0);
    @(posedge clk); #1;
    chk("mul_no_extra_accept", 32'(out_valid), 32'h0);

    // Reset in the middle of a multiply, then a fresh op
    apply(4'b1111, 16'd300, 16'd300);
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("mul_abort_reset", obs(), 32'h0);
    @(negedge clk) rst_n = 1'b1;
    stale = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (out_valid || out_res == 16'h5F90) stale = 1'b1;
    end
    chk("mul_abort_no_stale", 32'(stale), 32'h0);
    apply(4'b1110, 16'h00AB, 16'h00CD);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("post_abort_op", obs(), expv(1'b1, 1'b1, 1'b0, 1'b0, 16'hABCD));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
